ssd_scan_controller: RTL and testbench

Parameterised multiplexed seven-segment display controller for board-level debug readout. It time-multiplexes NUM_DIGITS hex digits from one of NUM_CH selectable 4*NUM_DIGITS-bit data channels onto shared active-low cathodes and anodes. It adds button-driven channel selection, frame-coherent latching, leading-zero blanking, decimal points and blink. It sits between the core debug buses / board switches and the FPGA display pins.

---
 rtl/ssd_pkg.sv | 14 +
 rtl/ssd_hex_decoder.sv | 9 +
 rtl/ssd_scan_controller.sv | 108 ++++++++++
 tb/tb_ssd_scan_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared segment constants, hex-to-segment table and channel-index width helper
package ssd_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: 4-bit hex nibble to active-low {a,b,c,d,e,f,g} segments
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = hex_seg(hex);
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: time-multiplexed hex display with channel select, frame latch,
// leading-zero blanking, decimal points and blink; all pin outputs come straight from flops
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int CLK_DIV     = 100000,
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_CH      = 5,
  parameter int BLINK_TICKS = 250,
  localparam int CH_W       = ch_w(NUM_CH),
  localparam int W          = 4 * NUM_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH*W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]     ch_sel_btn,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            CA,
  output logic                  DP,
  output logic [CH_W-1:0]       cur_ch
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;

  if (CLK_DIV < 2 || NUM_DIGITS < 2 || NUM_DIGITS > 8 || NUM_CH < 1 || NUM_CH > 8 || BLINK_TICKS < 1) begin : g_bad_params
    $error("ssd_scan_controller: illegal parameter value");
  end

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         bcnt;
  logic                  blink_phase, upd, tick, wrap, bend;
  logic [W-1:0]          snap;
  logic [NUM_DIGITS-1:0] snap_dp, blank_v;
  logic [NUM_CH-1:0]     s1, s2, s3, rise;
  logic                  hit, lead, blank;
  logic [CH_W-1:0]       sel;
  logic [3:0]            digit;
  logic [6:0]            seg;

  assign tick  = int'(pcnt) == CLK_DIV - 1;
  assign wrap  = tick && int'(idx) == NUM_DIGITS - 1;
  assign bend  = int'(bcnt) == BLINK_TICKS - 1;
  assign rise  = s2 & ~s3;
  assign digit = snap[{idx, 2'b00} +: 4];
  assign blank = blank_v[idx];

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (rise[i]) begin
        hit = 1'b1;
        sel = CH_W'(i);
      end
  end

  // a digit is blanked while it and every more-significant digit are zero; digit 0 always shows
  always_comb begin
    lead = 1'b1;
    blank_v = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead && (snap[i*4 +: 4] == 4'd0);
      blank_v[i] = blank_lz && lead;
    end
  end

  ssd_hex_decoder u_dec (.hex(digit), .seg(seg));

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pcnt        <= '0;
      idx         <= IW'(NUM_DIGITS - 1);
      bcnt        <= '0;
      blink_phase <= 1'b0;
      upd         <= 1'b0;
      snap        <= '0;
      snap_dp     <= '0;
      {s3, s2, s1} <= '0;
      cur_ch      <= '0;
      AN          <= '1;
      CA          <= SEG_BLANK;
      DP          <= 1'b1;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      upd  <= tick;
      {s3, s2, s1} <= {s2, s1, ch_sel_btn};
      if (hit) cur_ch <= sel;
      if (tick) begin
        idx  <= wrap ? '0 : idx + IW'(1);
        bcnt <= bend ? '0 : bcnt + BW'(1);
        if (bend) blink_phase <= ~blink_phase;
      end
      if (wrap) begin
        snap    <= ch_data[int'(cur_ch)*W +: W];
        snap_dp <= dp_in;
      end
      if (upd) begin
        AN <= (blank || (blink_en && blink_phase)) ? '1 : ~(NUM_DIGITS'(1) << idx);
        CA <= blank ? SEG_BLANK : seg;
        DP <= blank | ~snap_dp[idx];
      end
    end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: scoreboard bench; expectations keyed by cycle since reset release
module tb_ssd_scan_controller;
  localparam int ND = 4;
  localparam int NC = 5;
  localparam int CW = 3;

  logic            clock, reset;
  logic [NC*16-1:0] ch_data;
  logic [NC-1:0]   ch_sel_btn;
  logic [ND-1:0]   dp_in;
  logic            blank_lz, blink_en;
  logic [ND-1:0]   AN;
  logic [6:0]      CA;
  logic            DP;
  logic [CW-1:0]   cur_ch;

  ssd_scan_controller #(.CLK_DIV(4), .NUM_DIGITS(ND), .NUM_CH(NC), .BLINK_TICKS(2)) dut (
    .clock(clock), .reset(reset), .ch_data(ch_data), .ch_sel_btn(ch_sel_btn), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .AN(AN), .CA(CA), .DP(DP), .cur_ch(cur_ch)
  );

  typedef struct {
    int          cyc;
    bit          kind;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc, n_checks, n_fail;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push(input int c, input bit k, input logic [11:0] v, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.kind = k; e.exp = v; e.name = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  task automatic o(input int c, input logic [3:0] an, input logic [6:0] ca, input logic dp, input string nm);
    push(c, 1'b0, {an, ca, dp}, nm);
  endtask

  task automatic ch(input int c, input int v, input string nm);
    push(c, 1'b1, 12'(v), nm);
  endtask

  // channel 0 = 16'h7E5B: digits 0..3 decode to 60,24,30,0F
  task automatic push_timing(input int upto);
    logic [6:0] t [4] = '{7'h60, 7'h24, 7'h30, 7'h0F};
    for (int c = 1; c <= upto; c++)
      if (c < 5) o(c, 4'hF, 7'h7F, 1'b1, "idle");
      else o(c, ~(4'b0001 << (((c - 5) / 4) % 4)), t[((c - 5) / 4) % 4], 1'b1, "scan");
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [11:0] got;
    if (!reset)
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        got = e.kind ? 12'(cur_ch) : {AN, CA, DP};
        n_checks++;
        if (e.cyc != cyc || got !== e.exp) begin
          n_fail++;
          $display("FAIL %s@%0d: got %h expected %h (seen at cyc %0d)", e.name, e.cyc, got, e.exp, cyc);
        end
      end
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0;
    ch_data = {16'hC6D9, 16'h0000, 16'h0030, 16'h12AF, 16'h7E5B};
    ch_sel_btn = '0; dp_in = '0; blank_lz = 1'b0; blink_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_out", {AN, CA, DP}, {4'hF, 7'h7F, 1'b1});
    check("reset_ch", 12'(cur_ch), 12'd0);
    push_timing(20);
    ch(15, 0, "sel1_pending"); ch(16, 1, "sel1");
    o(21, 4'hE, 7'h38, 1'b1, "frame_d0"); o(24, 4'hE, 7'h38, 1'b1, "frame_d0_hold");
    o(25, 4'hD, 7'h08, 1'b1, "frame_d1"); o(29, 4'hB, 7'h12, 1'b1, "frame_d2");
    o(33, 4'h7, 7'h4F, 1'b1, "frame_d3");
    o(37, 4'hE, 7'h04, 1'b1, "new_d0"); o(41, 4'hD, 7'h04, 1'b1, "new_d1");
    o(45, 4'hB, 7'h04, 1'b1, "new_d2"); o(49, 4'h7, 7'h04, 1'b1, "new_d3");
    ch(40, 1, "simul_pending"); ch(41, 2, "simul"); ch(50, 2, "held_btn");
    o(53, 4'hE, 7'h01, 1'b1, "lz_d0"); o(57, 4'hD, 7'h06, 1'b0, "lz_d1_dp");
    o(61, 4'hF, 7'h7F, 1'b1, "lz_d2"); o(65, 4'hF, 7'h7F, 1'b1, "lz_d3");
    ch(57, 3, "sel3"); ch(62, 3, "btn_fall");
    o(69, 4'hE, 7'h01, 1'b1, "zero_d0"); o(73, 4'hF, 7'h7F, 1'b1, "zero_d1_dp");
    o(77, 4'hF, 7'h7F, 1'b1, "zero_d2"); o(81, 4'hF, 7'h7F, 1'b1, "zero_d3");
    ch(73, 4, "sel4");
    o(85, 4'hE, 7'h04, 1'b1, "blink_d0"); o(89, 4'hF, 7'h42, 1'b1, "blink_d1");
    o(91, 4'hF, 7'h42, 1'b1, "blink_hold"); o(93, 4'hF, 7'h20, 1'b1, "blink_d2");
    o(97, 4'h7, 7'h31, 1'b1, "blink_d3"); o(101, 4'hE, 7'h04, 1'b1, "blink_d0b");
    o(105, 4'hF, 7'h42, 1'b1, "blink_d1b");
    o(109, 4'hB, 7'h20, 1'b1, "unblink_d2"); o(113, 4'h7, 7'h31, 1'b1, "unblink_d3");
    o(117, 4'hE, 7'h04, 1'b1, "unblink_d0"); o(121, 4'hD, 7'h42, 1'b1, "unblink_d1");
    o(125, 4'hB, 7'h20, 1'b1, "pre_reset_d2");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    at(13); ch_sel_btn = 5'b00010;
    at(15); ch_sel_btn = 5'b00000;
    at(26); ch_data[31:16] = 16'h9999;
    at(38); ch_sel_btn = 5'b10100;
    at(42); ch_sel_btn = 5'b10000;
    at(50); blank_lz = 1'b1; dp_in = 4'b0010;
    at(54); ch_sel_btn = 5'b11000;
    at(58); ch_sel_btn = 5'b10000;
    at(60); ch_sel_btn = 5'b00000;
    at(70); ch_sel_btn = 5'b10000;
    at(76); ch_sel_btn = 5'b00000;
    at(82); blank_lz = 1'b0; dp_in = 4'b0000; blink_en = 1'b1;
    at(106); blink_en = 1'b0;
    at(126);
    #2 reset = 1'b1;
    #1;
    check("midscan_reset_out", {AN, CA, DP}, {4'hF, 7'h7F, 1'b1});
    check("midscan_reset_ch", 12'(cur_ch), 12'd0);
    push_timing(24);
    ch(10, 0, "ch_after_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clock);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s@%0d: never checked, expected %h", e.name, e.cyc, e.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
